// File: rtl/p2s_conv_nx1.sv
// p2s_conv_nx1: W-bit words in over valid/ready, one bit out per sink request.
// A one-word holding buffer refills while the shifter drains, so the output is gapless.
//
// state          | meaning
// idle  (busy=0) | shifter empty; a buffered word moves into it on the next edge
// shift (busy=1) | shifter presents bit cnt of the current word on odat
module p2s_conv_nx1 #(
  parameter int W         = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic [W-1:0] idat,
  input  logic         ival,
  input  logic         isop,
  input  logic         ieop,
  output logic         oreq,
  input  logic         ireq,
  output logic         oval,
  output logic         odat,
  output logic         osop,
  output logic         oeop
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [W-1:0]  hbuf, hbuf_nxt;
  logic          hval, hval_nxt;
  logic          hsop, hsop_nxt;
  logic          heop, heop_nxt;
  logic [W-1:0]  sreg, sreg_nxt;
  logic          busy, busy_nxt;
  logic          ssop, ssop_nxt;
  logic          seop, seop_nxt;
  logic [CW-1:0] cnt,  cnt_nxt;

  logic accept;
  logic last;
  logic xfer;

  assign accept = ival & ~hval;
  assign last   = busy & ireq & (cnt == CNT_LAST);
  assign xfer   = hval & (~busy | last);

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      hbuf <= '0;
      hval <= 1'b0;
      hsop <= 1'b0;
      heop <= 1'b0;
      sreg <= '0;
      busy <= 1'b0;
      ssop <= 1'b0;
      seop <= 1'b0;
      cnt  <= '0;
    end else begin
      hbuf <= hbuf_nxt;
      hval <= hval_nxt;
      hsop <= hsop_nxt;
      heop <= heop_nxt;
      sreg <= sreg_nxt;
      busy <= busy_nxt;
      ssop <= ssop_nxt;
      seop <= seop_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    hbuf_nxt = hbuf;
    hval_nxt = hval;
    hsop_nxt = hsop;
    heop_nxt = heop;
    sreg_nxt = sreg;
    busy_nxt = busy;
    ssop_nxt = ssop;
    seop_nxt = seop;
    cnt_nxt  = cnt;

    // accept needs an empty buffer and xfer a full one, so they never coincide
    if (accept) begin
      hbuf_nxt = idat;
      hsop_nxt = isop;
      heop_nxt = ieop;
      hval_nxt = 1'b1;
    end

    if (xfer) begin
      sreg_nxt = hbuf;
      ssop_nxt = hsop;
      seop_nxt = heop;
      busy_nxt = 1'b1;
      cnt_nxt  = '0;
      hval_nxt = 1'b0;
    end else if (last) begin
      busy_nxt = 1'b0;
      cnt_nxt  = '0;
    end else if (busy && ireq) begin
      cnt_nxt = cnt + 1'b1;
      if (MSB_FIRST != 0) sreg_nxt = {sreg[W-2:0], 1'b0};
      else                sreg_nxt = {1'b0, sreg[W-1:1]};
    end
  end

  always_comb begin
    oreq = ~hval;
    oval = busy;
    odat = (MSB_FIRST != 0) ? sreg[W-1] : sreg[0];
    osop = busy & ssop & (cnt == '0);
    oeop = busy & seop & (cnt == CNT_LAST);
  end

endmodule

// File: tb/tb_p2s_conv_nx1.sv
// Bench for p2s_conv_nx1: four instances (W4 msb, W4 lsb, W8 msb, W2 msb) checked
// against a bit-queue model plus literal expectations for each directed scenario.
module tb_p2s_conv_nx1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] dat [4];
  logic val [4];
  logic sop [4];
  logic eop [4];
  logic rq [4];
  logic oreq_o [4];
  logic oval_o [4];
  logic odat_o [4];
  logic osop_o [4];
  logic oeop_o [4];

  int total = 0;
  int bad = 0;

  logic [2:0] expq [4][$];
  logic [2:0] cap [4][$];
  int run_len [4];
  int max_run [4];

  logic [7:0] wq [$];
  logic ws [$];
  logic we [$];
  int acc_cyc [$];

  always #5 clk = ~clk;

  p2s_conv_nx1 #(.W(4), .MSB_FIRST(1)) u0 (
    .iclk(clk), .irst(rst_n), .idat(dat[0][3:0]), .ival(val[0]), .isop(sop[0]), .ieop(eop[0]),
    .oreq(oreq_o[0]), .ireq(rq[0]), .oval(oval_o[0]), .odat(odat_o[0]), .osop(osop_o[0]), .oeop(oeop_o[0]));
  p2s_conv_nx1 #(.W(4), .MSB_FIRST(0)) u1 (
    .iclk(clk), .irst(rst_n), .idat(dat[1][3:0]), .ival(val[1]), .isop(sop[1]), .ieop(eop[1]),
    .oreq(oreq_o[1]), .ireq(rq[1]), .oval(oval_o[1]), .odat(odat_o[1]), .osop(osop_o[1]), .oeop(oeop_o[1]));
  p2s_conv_nx1 #(.W(8), .MSB_FIRST(1)) u2 (
    .iclk(clk), .irst(rst_n), .idat(dat[2]), .ival(val[2]), .isop(sop[2]), .ieop(eop[2]),
    .oreq(oreq_o[2]), .ireq(rq[2]), .oval(oval_o[2]), .odat(odat_o[2]), .osop(osop_o[2]), .oeop(oeop_o[2]));
  p2s_conv_nx1 #(.W(2), .MSB_FIRST(1)) u3 (
    .iclk(clk), .irst(rst_n), .idat(dat[3][1:0]), .ival(val[3]), .isop(sop[3]), .ieop(eop[3]),
    .oreq(oreq_o[3]), .ireq(rq[3]), .oval(oval_o[3]), .odat(odat_o[3]), .osop(osop_o[3]), .oeop(oeop_o[3]));

  function automatic int wd(int i);
    case (i)
      0, 1:    return 4;
      2:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic bit msb(int i);
    return i != 1;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Captured stream as a vector, first bit most significant; f: 2=data 1=sop 0=eop
  function automatic logic [63:0] capv(int i, int f);
    logic [63:0] v = '0;
    logic [2:0]  e;
    for (int j = 0; j < cap[i].size(); j++) begin
      e = cap[i][j];
      v = {v[62:0], e[f]};
    end
    return v;
  endfunction

  // Model: every accepted word becomes W expected bits in send order
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        check($sformatf("u%0d_rst_oval", i), 64'(oval_o[i]), 64'd0);
        check($sformatf("u%0d_rst_odat", i), 64'(odat_o[i]), 64'd0);
        check($sformatf("u%0d_rst_flags", i), 64'({osop_o[i], oeop_o[i]}), 64'd0);
        check($sformatf("u%0d_rst_oreq", i), 64'(oreq_o[i]), 64'd1);
        expq[i].delete();
        run_len[i] = 0;
      end else begin
        if (oval_o[i]) begin
          run_len[i]++;
          if (run_len[i] > max_run[i]) max_run[i] = run_len[i];
          if (expq[i].size() == 0) begin
            check($sformatf("u%0d_spurious_oval", i), 64'd1, 64'd0);
          end else begin
            check($sformatf("u%0d_serial_bit", i), 64'({odat_o[i], osop_o[i], oeop_o[i]}), 64'(expq[i][0]));
            if (rq[i]) begin
              void'(expq[i].pop_front());
              cap[i].push_back({odat_o[i], osop_o[i], oeop_o[i]});
            end
          end
        end else begin
          run_len[i] = 0;
          check($sformatf("u%0d_idle_flags", i), 64'({osop_o[i], oeop_o[i]}), 64'd0);
        end
        if (val[i] && oreq_o[i]) begin
          for (int b = 0; b < wd(i); b++) begin
            int idx;
            idx = msb(i) ? wd(i) - 1 - b : b;
            expq[i].push_back({dat[i][idx], sop[i] && (b == 0), eop[i] && (b == wd(i) - 1)});
          end
        end
      end
    end
  end

  // mode 0: ireq held 1; mode 1: ireq random; mode 2: ireq low 8 cycles, then random
  task automatic run(int i, int mode, string tag);
    int k = 0;
    int cyc = 0;
    bit acc;
    max_run[i] = 0;
    acc_cyc.delete();
    cap[i].delete();
    while ((k < wq.size() || expq[i].size() != 0) && cyc < 3000) begin
      val[i] = (k < wq.size());
      if (k < wq.size()) begin
        dat[i] = wq[k];
        sop[i] = ws[k];
        eop[i] = we[k];
      end
      if (mode == 0)                  rq[i] = 1'b1;
      else if (mode == 2 && cyc < 8)  rq[i] = 1'b0;
      else                            rq[i] = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = val[i] && oreq_o[i];
      if (mode == 2 && cyc == 8) begin
        check({tag, "_full_oreq"}, 64'(oreq_o[i]), 64'd0);
        check({tag, "_full_words"}, 64'(k), 64'd2);
        check({tag, "_full_oval"}, 64'(oval_o[i]), 64'd1);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cyc.push_back(cyc);
        k++;
      end
      cyc++;
    end
    if (cyc >= 3000) check({tag, "_timeout"}, 64'd1, 64'd0);
    val[i] = 1'b0;
    rq[i] = 1'b0;
    check({tag, "_oval_fall"}, 64'(oval_o[i]), 64'd0);
  endtask

  initial begin
    int bad_iv;
    for (int i = 0; i < 4; i++) begin
      dat[i] = '0; val[i] = 0; sop[i] = 0; eop[i] = 0; rq[i] = 0;
      run_len[i] = 0; max_run[i] = 0;
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word, msb first
    wq = '{8'h0B}; ws = '{1'b1}; we = '{1'b1};
    run(0, 0, "msb_word");
    check("msb_word_data", capv(0, 2), 64'hB);
    check("msb_word_sop", capv(0, 1), 64'h8);
    check("msb_word_eop", capv(0, 0), 64'h1);
    check("msb_word_run", 64'(max_run[0]), 64'd4);

    // single word, lsb first: 1011 -> 1,1,0,1
    run(1, 0, "lsb_word");
    check("lsb_word_data", capv(1, 2), 64'hD);
    check("lsb_word_sop", capv(1, 1), 64'h8);
    check("lsb_word_eop", capv(1, 0), 64'h1);

    // 16 back-to-back bytes
    wq.delete(); ws.delete(); we.delete();
    for (int j = 0; j < 16; j++) begin
      wq.push_back(8'($urandom));
      ws.push_back(j == 0);
      we.push_back(j == 15);
    end
    run(2, 0, "b2b");
    check("b2b_run", 64'(max_run[2]), 64'd128);
    check("b2b_accepts", 64'(acc_cyc.size()), 64'd16);
    bad_iv = 0;
    for (int j = 2; j < acc_cyc.size(); j++)
      if (acc_cyc[j] - acc_cyc[j-1] != 8) bad_iv++;
    check("b2b_oreq_period", 64'(bad_iv), 64'd0);
    check("b2b_bits", 64'(cap[2].size()), 64'd128);

    // backpressure with random sink
    wq = '{8'h0A, 8'h03, 8'h0E}; ws = '{1'b1, 1'b0, 1'b0}; we = '{1'b0, 1'b0, 1'b1};
    run(0, 2, "bp");
    check("bp_data", capv(0, 2), 64'hA3E);
    check("bp_sop", capv(0, 1), 64'h800);
    check("bp_eop", capv(0, 0), 64'h001);

    // reset after bit 2 of 1100 with 1010 buffered
    cap[0].delete();
    val[0] = 1; dat[0] = 8'h0C; sop[0] = 1; eop[0] = 1; rq[0] = 1;
    @(posedge clk); #1;
    dat[0] = 8'h0A; sop[0] = 0; eop[0] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    val[0] = 0;
    @(posedge clk); #1;
    check("rst_mid_bits", capv(0, 2), 64'h3);
    check("rst_mid_sop", capv(0, 1), 64'h2);
    check("rst_mid_count", 64'(cap[0].size()), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_now_oval", 64'(oval_o[0]), 64'd0);
    check("rst_now_odat", 64'(odat_o[0]), 64'd0);
    check("rst_now_flags", 64'({osop_o[0], oeop_o[0]}), 64'd0);
    check("rst_now_oreq", 64'(oreq_o[0]), 64'd1);
    rq[0] = 0;
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rq[0] = 1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("rst_after_oval", 64'(oval_o[0]), 64'd0);
    end
    wq = '{8'h06}; ws = '{1'b1}; we = '{1'b0};
    run(0, 0, "post_rst");
    check("post_rst_data", capv(0, 2), 64'h6);
    check("post_rst_sop", capv(0, 1), 64'h8);
    check("post_rst_eop", capv(0, 0), 64'h0);

    // W=2 three-word packet
    wq = '{8'h02, 8'h01, 8'h03}; ws = '{1'b1, 1'b0, 1'b0}; we = '{1'b0, 1'b0, 1'b1};
    run(3, 0, "w2pkt");
    check("w2pkt_data", capv(3, 2), 64'h27);
    check("w2pkt_sop", capv(3, 1), 64'h20);
    check("w2pkt_eop", capv(3, 0), 64'h01);
    check("w2pkt_run", 64'(max_run[3]), 64'd6);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p2s_conv_nx1.md
# p2s_conv_nx1

Parametrised parallel-to-serial converter for the DeFEC datapath. It accepts W-bit words over a valid/ready handshake and emits them one bit per cycle whenever the downstream sink requests a bit. A one-word holding buffer lets the next word load while the current one shifts, so output is gapless, and bit order is selectable. Packet framing (sop/eop) is carried through to the first and last serial bit of each word.

## Interface
- W, 4: word width in bits; legal range 2..64.
- MSB_FIRST, 1: 1 sends idat[W-1] first; 0 sends idat[0] first.
- iclk  in  1  clock; all logic on the rising edge.
- irst  in  1  asynchronous, active-low reset.
- idat  in  W  parallel word.
- ival  in  1  idat, isop and ieop are valid.
- isop  in  1  the word is the first of a packet.
- ieop  in  1  the word is the last of a packet.
- oreq  out 1  ready; a word is accepted on a cycle with ival & oreq.
- ireq  in  1  sink ready; a bit is consumed on a cycle with ireq & oval.
- oval  out 1  odat holds a valid bit.
- odat  out 1  serial bit.
- osop  out 1  current bit is bit 0 of a word accepted with isop.
- oeop  out 1  current bit is bit W-1 of a word accepted with ieop.

## Operation
- State:
  - Holding buffer: hbuf[W-1:0], hval, hsop, heop.
  - Shifter: sreg[W-1:0], busy, ssop, seop.
  - Bit counter: cnt, width $clog2(W).
- Accept:
  - oreq = ~hval (combinational).
  - On ival & oreq, load hbuf, hsop and heop from idat, isop and ieop, and set hval.
  - ival without oreq is ignored; the upstream must hold its word.
- Transfer from buffer to shifter happens when hval & (~busy | last), where last = busy & ireq & (cnt == W-1). On transfer:
  - sreg <= hbuf, ssop <= hsop, seop <= heop.
  - busy <= 1, cnt <= 0, hval <= 0.
  - A new accept cannot happen in the same cycle, because oreq was 0.
- Shift, on busy & ireq without last:
  - cnt increments.
  - sreg shifts left when MSB_FIRST=1 and right when MSB_FIRST=0, filling with 0.
- Completion: on last with ~hval, busy <= 0 and cnt <= 0.
- Outputs, all combinational from registers:
  - oval = busy.
  - odat = sreg[W-1] when MSB_FIRST=1, sreg[0] when MSB_FIRST=0.
  - osop = busy & ssop & (cnt == 0).
  - oeop = busy & seop & (cnt == W-1).
- Stall: while ireq is low, sreg, cnt, odat, osop and oeop hold, and oval stays high if busy.
- A word with both isop and ieop set gives osop on its first bit and oeop on its last bit.
- The block performs no framing checks; sop and eop pass through unmodified.

## Timing
- Reset (irst low), effective immediately:
  - hval, busy, ssop, seop, hsop, heop, cnt, sreg and hbuf all go to 0.
  - oval, odat, osop and oeop read 0; oreq reads 1.
  - The upstream must keep ival low during reset.
- Reset mid-word discards the partial word and the buffered word with no further output. The first word after release starts cleanly at bit 0.
- Latency: a word accepted at edge t sets hval after t. It transfers at edge t+1 if the shifter is idle, so its first bit is on odat in cycle t+1 to t+2 (2 cycles from the accept cycle to the first oval).
- Throughput: with ival and ireq held high, output is W bits per W cycles with no bubble for every W ≥ 2.
  - oreq is high for 1 cycle per word: the cycle after each transfer.
- Backpressure: if ireq stays low, the block holds at most 2 words (shifter plus buffer), then oreq stays 0.
- Simultaneous last bit and full buffer: the transfer happens on the same edge, and the next cycle shows bit 0 of the new word with no gap.

## Test plan
- W=4, MSB_FIRST=1, single word 4'b1011 with isop=ieop=1, ireq held 1:
  - odat = 1,0,1,1 over four consecutive oval cycles.
  - osop only on the first bit, oeop only on the fourth.
  - oval falls after the fourth bit.
- W=4, MSB_FIRST=0, word 4'b1011 → odat = 1,1,0,1.
- W=8, 16 back-to-back random words, ival and ireq held 1:
  - 128 consecutive oval cycles with no gap.
  - Serial stream matches the words in order.
  - oreq pulses once per 8 cycles.
- W=4, ireq toggled pseudo-randomly (50%) while 3 words are offered:
  - odat and cnt hold during ireq=0.
  - oreq stays 0 once 2 words are stored.
  - All 12 bits are delivered correctly.
- W=4, irst pulsed low after the 2nd bit of word 4'b1100 with a second word buffered:
  - All outputs read 0 immediately and no further bits of either word appear.
  - Next word 4'b0110 → 0,1,1,0 with osop per its isop.
- W=2, 3-word packet (isop on word 0, ieop on word 2):
  - osop once on bit 0 of word 0, oeop once on bit 1 of word 2.
  - 6 contiguous oval cycles.
